// File: rtl/reg_dump_unit.sv
// Register-file dump engine: walks an inclusive, possibly wrapping address range
// through a combinational read port and streams each register out as a valid/ready beat.
module reg_dump_unit #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [SIZE-1:0]  first_reg_i,
    input  logic [SIZE-1:0]  last_reg_i,
    output logic [SIZE-1:0]  read_register_1_o,
    input  logic [WIDTH-1:0] read_data_1_i,
    output logic             dump_valid_o,
    input  logic             dump_ready_i,
    output logic [SIZE-1:0]  dump_addr_o,
    output logic [WIDTH-1:0] dump_data_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [SIZE-1:0]  ptr_reg, ptr_next;
    logic [SIZE-1:0]  last_reg, last_next;
    logic [SIZE-1:0]  addr_reg, addr_next;
    logic [WIDTH-1:0] data_reg, data_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            last_reg  <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            last_reg  <= last_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        last_next  = last_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    ptr_next   = first_reg_i;
                    last_next  = last_reg_i;
                    state_next = READ;
                end
            end
            READ: begin
                // Capture the beat so later register-file writes cannot disturb it.
                addr_next  = ptr_reg;
                data_next  = read_data_1_i;
                state_next = VALID;
            end
            VALID: begin
                if (dump_ready_i) begin
                    if (ptr_reg == last_reg) begin
                        state_next = DONE;
                    end else begin
                        // Natural overflow gives the wrap from 2^SIZE-1 back to 0.
                        ptr_next   = ptr_reg + SIZE'(1);
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state register, so reset clears them at once.
    assign read_register_1_o = ptr_reg;
    assign dump_addr_o       = addr_reg;
    assign dump_data_o       = data_reg;
    assign dump_valid_o      = (state_reg == VALID);
    assign busy_o            = (state_reg != IDLE);
    assign done_o            = (state_reg == DONE);

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter SIZE, default 5, register address width (2^SIZE registers).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  request a dump; sampled only in IDLE.
REQ-007 first_reg_i  input  SIZE  first register of the dump range; latched on accepted start.
REQ-008 last_reg_i  input  SIZE  last register of the dump range, inclusive; latched on accepted start.
REQ-009 read_register_1_o  output  SIZE  address to the register file read port 1.
REQ-010 read_data_1_i  input  WIDTH  combinational read data from register file port 1.
REQ-011 dump_valid_o  output  1  dump beat valid.
REQ-012 dump_ready_i  input  1  consumer accepts the beat.
REQ-013 dump_addr_o  output  SIZE  register index of the current beat.
REQ-014 dump_data_o  output  WIDTH  register contents of the current beat.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 done_o  output  1  one-cycle pulse at dump completion.

Function
REQ-017 FSM states SHALL be IDLE, READ, VALID and DONE, with internal pointer ptr[SIZE-1:0] and latched last_q.
REQ-018 IDLE: start_i=1 at an edge -> ptr<=first_reg_i, last_q<=last_reg_i, next state READ; otherwise stay in IDLE.
REQ-019 read_register_1_o SHALL equal ptr in all states (registered pointer, no combinational path from inputs).
REQ-020 READ: at the edge, dump_data_o<=read_data_1_i, dump_addr_o<=ptr, next state VALID; READ SHALL last exactly one cycle.
REQ-021 VALID: dump_valid_o=1; dump_addr_o and dump_data_o SHALL stay stable while dump_ready_i=0.
REQ-022 VALID with dump_ready_i=1 and ptr==last_q -> next state DONE.
REQ-023 VALID with dump_ready_i=1 and ptr!=last_q -> ptr<=ptr+1 modulo 2^SIZE, next state READ.
REQ-024 Throughput SHALL be one beat per 2 cycles maximum; first dump_valid_o SHALL occur 2 cycles after the start edge.
REQ-025 last_reg_i < first_reg_i SHALL wrap through 2^SIZE-1 to 0; first==last SHALL produce exactly one beat; the number of beats SHALL be ((last-first) mod 2^SIZE)+1.
REQ-026 DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 start_i asserted while busy_o=1 SHALL be ignored, with no queueing.
REQ-028 dump_valid_o SHALL be 0 in IDLE, READ and DONE.
REQ-029 The block SHALL NOT write the register file; it is a read-only initiator.

Reset
REQ-030 reset=0 SHALL immediately, with no clock required, force state IDLE, ptr=0, last_q=0, dump_addr_o=0, dump_data_o=0, dump_valid_o=0, busy_o=0 and done_o=0.
REQ-031 Reset asserted mid-dump SHALL abort the dump with no further beats and no done_o pulse; a new start after deassertion SHALL behave as the first dump.
REQ-032 The first edge after reset deassertion SHALL be able to accept start_i.

Verification
REQ-033 Full dump: preload the register file with r2=7, r4=20, r25=6, r31=78 (all others 0); first=0, last=31; ready held high -> 32 beats with addresses 0..31, data 7/20/6/78 at those indices, and done_o 65 cycles after the start edge.
REQ-034 Backpressure: first=last=4, dump_ready_i low for 5 cycles -> dump_valid_o held with addr 4 and data 20 stable, one beat only, then done_o.
REQ-035 Wrap: first=30, last=1 -> beats at addresses 30, 31, 0, 1, then done_o.
REQ-036 Ignored start: pulse start_i during beat 3 of a 0..31 dump -> beat count stays 32 and no second dump follows.
REQ-037 Reset abort: assert reset during VALID at addr 25 -> all outputs 0 within the same cycle; a restart with 2..2 yields a single beat with data 7.
REQ-038 Live data: change r25 while the dump sits in VALID at addr 25 -> dump_data_o keeps the captured value 6.
